// File: rtl/ahb_mem_slave_pkg.sv
// ahb_mem_slave_pkg: AHB-Lite encodings, slave FSM states and byte-lane enable helper
package ahb_mem_slave_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NON_SEQ = 2'd2, SEQ = 2'd3} htrans_t;
  typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} hburst_t;
  typedef enum logic [2:0] {SIZE_BYTE = 3'd0, SIZE_HALF = 3'd1, SIZE_WORD = 3'd2} hsize_t;
  typedef enum logic [2:0] {ST_ADDR, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} slave_state_t;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  function automatic logic [3:0] lane_en(logic [2:0] size, logic [1:0] lo);
    return size == SIZE_WORD ? 4'hf : size == SIZE_HALF ? 4'h3 << lo : 4'h1 << lo;
  endfunction
endpackage

// File: rtl/ahb_mem_array.sv
// ahb_mem_array: word-addressed RAM with per-byte write enables and asynchronous read
module ahb_mem_array #(
  parameter int WORDS = 512,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [WORDS];
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite memory slave with read-only region heads, wait states and two-cycle ERROR
module ahb_mem_slave
  import ahb_mem_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int NUM_SLAVES  = 2,
  parameter int RO_BYTES    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  reset,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int TOTAL = NUM_SLAVES * MEM_BYTES;
  localparam int OW    = $clog2(MEM_BYTES);
  localparam int AW    = $clog2(TOTAL);
  slave_state_t    r_state;
  logic [AW-1:0]   r_addr;
  logic            r_write;
  logic [2:0]      r_size;
  logic [3:0]      r_cnt;
  logic            w_take, w_err, w_misalign, w_unused;
  logic [3:0]      w_we;
  logic [DATA_WIDTH-1:0] w_rdata;
  assign w_unused   = ^HBURST;
  assign w_take     = HREADY & HSEL & (HTRANS == NON_SEQ || HTRANS == SEQ);
  assign w_misalign = HSIZE == SIZE_HALF ? HADDR[0] : HSIZE == SIZE_WORD ? |HADDR[1:0] : 1'b0;
  assign w_err      = HADDR >= ADDR_WIDTH'(TOTAL) || (HWRITE && HADDR[OW-1:0] < OW'(RO_BYTES)) ||
                      HSIZE > SIZE_WORD || w_misalign;
  // HREADY/HRESP are registered from the next state so they hold for the whole cycle
  always_ff @(posedge HCLK or posedge reset)
    if (reset) begin
      r_state <= ST_ADDR;
      HREADY  <= 1'b1;
      HRESP   <= HRESP_OKAY;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_cnt   <= '0;
    end else if (w_take) begin
      r_addr  <= HADDR[AW-1:0];
      r_write <= HWRITE;
      r_size  <= HSIZE;
      r_cnt   <= 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
      r_state <= w_err ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_DATA;
      HREADY  <= !w_err && WAIT_STATES == 0;
      HRESP   <= w_err ? HRESP_ERROR : HRESP_OKAY;
    end else if (r_state == ST_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
      r_state <= r_cnt == 4'd0 ? ST_DATA : ST_WAIT;
      HREADY  <= r_cnt == 4'd0;
    end else begin
      r_state <= r_state == ST_ERR1 ? ST_ERR2 : ST_ADDR;
      HREADY  <= 1'b1;
      HRESP   <= r_state == ST_ERR1 ? HRESP_ERROR : HRESP_OKAY;
    end
  assign w_we   = r_state == ST_DATA && r_write ? lane_en(r_size, r_addr[1:0]) : 4'h0;
  assign HRDATA = r_state == ST_DATA && !r_write ? w_rdata : '0;
  ahb_mem_array #(.WORDS(TOTAL / 4)) u_mem (
    .clk    (HCLK),
    .i_we   (w_we),
    .i_addr (r_addr[AW-1:2]),
    .i_wdata(HWDATA),
    .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: drives two slaves (0 and 2 wait states) with pipelined transfers and checks
// every response against a byte-level memory model and hand-written vectors
module tb_ahb_mem_slave;
  localparam int NB = 2048;
  typedef struct {
    logic [31:0] addr; logic wr; logic [2:0] size; logic [31:0] wdata;
    logic e_err; logic [31:0] e_mask; logic [31:0] e_rdata;
  } xfer_t;
  typedef struct {
    logic [31:0] addr; logic wr; logic [2:0] size; logic [31:0] wdata;
    logic err; logic chk; logic [31:0] rdata;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic hsel = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0] htrans = 2'd0;
  logic [2:0] hsize = 3'd0, hburst = 3'd0;
  logic rdy0, rdy2, rsp0, rsp2;
  logic [31:0] rd0, rd2;
  int sel = 0;
  int checks = 0, failures = 0;
  xfer_t q[$];
  vec_t tbl[23];
  logic [7:0] mem_m[2][NB];
  bit known[2][NB];
  always #5 clk = ~clk;
  ahb_mem_slave #(.WAIT_STATES(0)) u0 (
    .HCLK(clk), .reset(rst), .HSEL(hsel && sel == 0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy0), .HRESP(rsp0), .HRDATA(rd0));
  ahb_mem_slave #(.WAIT_STATES(2)) u2 (
    .HCLK(clk), .reset(rst), .HSEL(hsel && sel == 1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy2), .HRESP(rsp2), .HRDATA(rd2));
  function automatic logic c_rdy(); return sel != 0 ? rdy2 : rdy0; endfunction
  function automatic logic c_rsp(); return sel != 0 ? rsp2 : rsp0; endfunction
  function automatic logic [31:0] c_rd(); return sel != 0 ? rd2 : rd0; endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic bit rule_err(logic [31:0] a, logic w, logic [2:0] s);
    if (a >= NB) return 1'b1;
    if (w && (a % 1024) < 4) return 1'b1;
    if (s > 3'd2) return 1'b1;
    return (a % (32'd1 << s)) != 0;
  endfunction
  // Applies a transfer to the byte model in issue order and returns it with expectations filled in
  function automatic xfer_t model(xfer_t x);
    int base;
    x.e_err = rule_err(x.addr, x.wr, x.size);
    x.e_mask = '0;
    x.e_rdata = '0;
    base = int'(x.addr) & ~3;
    if (!x.e_err) begin
      if (x.wr)
        for (int b = 0; b < (1 << x.size); b++) begin
          mem_m[sel][int'(x.addr) + b] = x.wdata[8*((int'(x.addr) + b) % 4) +: 8];
          known[sel][int'(x.addr) + b] = 1'b1;
        end
      else
        for (int b = 0; b < 4; b++)
          if (known[sel][base + b]) begin
            x.e_mask[8*b +: 8] = 8'hff;
            x.e_rdata[8*b +: 8] = mem_m[sel][base + b];
          end
    end
    return x;
  endfunction
  task automatic add(logic [31:0] a, logic w, logic [2:0] s, logic [31:0] d);
    xfer_t x;
    x.addr = a; x.wr = w; x.size = s; x.wdata = d;
    q.push_back(model(x));
  endtask
  task automatic present(int i);
    if (i < q.size()) begin
      hsel = 1'b1; htrans = 2'd2; haddr = q[i].addr; hwrite = q[i].wr; hsize = q[i].size;
    end else
      htrans = 2'd0;
  endtask
  // Issues the queued transfers back-to-back with AHB pipelining and checks each completion
  task automatic run_seq(string tag);
    int n, i, d, cyc, lim, bad_rd, ws;
    int wt[256], el[256];
    logic rs[256];
    logic [31:0] rdv[256];
    logic prev, r, p, ok;
    logic [31:0] v;
    n = q.size(); i = 0; d = -1; cyc = 0; bad_rd = 0;
    ws = sel != 0 ? 2 : 0;
    lim = n * 6 + 10;
    for (int k = 0; k < n; k++) begin wt[k] = 0; el[k] = 0; rs[k] = 1'bx; rdv[k] = 'x; end
    present(0);
    prev = c_rdy();
    while ((d >= 0 || i < n) && cyc < lim) begin
      @(posedge clk); #1;
      cyc++;
      if (prev) begin
        d = i < n ? i : -1;
        i = i < n ? i + 1 : i;
        present(i);
        hwdata = d >= 0 ? q[d].wdata : '0;
      end
      r = c_rdy(); p = c_rsp(); v = c_rd();
      if (d >= 0) begin
        if (!r) begin
          if (p) el[d]++; else wt[d]++;
        end else begin
          rs[d] = p; rdv[d] = v;
        end
      end
      if (v !== '0 && !(d >= 0 && r && !p && !q[d].wr)) bad_rd++;
      prev = r;
    end
    if (d >= 0 || i < n) begin
      failures++; checks++;
      $display("FAIL %s timeout: got %0d of %0d transfers issued", tag, i, n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      ok = q[k].e_err ? (rs[k] === 1'b1 && el[k] == 1 && wt[k] == 0)
                      : (rs[k] === 1'b0 && el[k] == 0 && wt[k] == ws &&
                         (rdv[k] & q[k].e_mask) === (q[k].e_rdata & q[k].e_mask));
      if (!ok) begin
        failures++;
        $display("FAIL %s xfer%0d @%h wr=%0d sz=%0d: got resp=%b errlow=%0d waits=%0d rdata=%h want err=%b waits=%0d rdata=%h mask=%h",
                 tag, k, q[k].addr, q[k].wr, q[k].size, rs[k], el[k], wt[k], rdv[k],
                 q[k].e_err, q[k].e_err ? 0 : ws, q[k].e_rdata, q[k].e_mask);
      end
    end
    chk({tag, " hrdata_zero_outside_read"}, bad_rd, 0);
    q.delete();
  endtask
  task automatic gen_rand(int cnt);
    int r;
    logic [31:0] a;
    logic [2:0] s;
    for (int k = 0; k < cnt; k++) begin
      r = $urandom_range(0, 9);
      a = r < 6 ? 32'($urandom_range(0, 63)) : r < 8 ? 32'h400 + 32'($urandom_range(0, 63)) :
          r < 9 ? 32'h7C0 + 32'($urandom_range(0, 63)) : 32'($urandom);
      s = $urandom_range(0, 9) < 9 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      add(a, 1'($urandom_range(0, 1)), s, 32'($urandom));
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    xfer_t x;
    tbl = '{
      '{32'h010, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0},
      '{32'h010, 1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF},
      '{32'h800, 1'b1, 3'd2, 32'h12345678, 1'b1, 1'b0, 32'h0},
      '{32'h800, 1'b0, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0},
      '{32'h000, 1'b1, 3'd2, 32'h00000001, 1'b1, 1'b0, 32'h0},
      '{32'h400, 1'b1, 3'd2, 32'h00000001, 1'b1, 1'b0, 32'h0},
      '{32'h000, 1'b0, 3'd2, 32'h0,        1'b0, 1'b0, 32'h0},
      '{32'h020, 1'b1, 3'd2, 32'h11223344, 1'b0, 1'b0, 32'h0},
      '{32'h021, 1'b1, 3'd0, 32'h0000AA00, 1'b0, 1'b0, 32'h0},
      '{32'h020, 1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'h1122AA44},
      '{32'h023, 1'b1, 3'd1, 32'hFFFF0000, 1'b1, 1'b0, 32'h0},
      '{32'h030, 1'b1, 3'd3, 32'h0,        1'b1, 1'b0, 32'h0},
      '{32'h404, 1'b1, 3'd2, 32'h55667788, 1'b0, 1'b0, 32'h0},
      '{32'h406, 1'b1, 3'd1, 32'hBEEF0000, 1'b0, 1'b0, 32'h0},
      '{32'h404, 1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'hBEEF7788},
      '{32'h7FC, 1'b1, 3'd2, 32'h01020304, 1'b0, 1'b0, 32'h0},
      '{32'h7FC, 1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'h01020304},
      '{32'h012, 1'b0, 3'd1, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF},
      '{32'h003, 1'b1, 3'd0, 32'h55000000, 1'b1, 1'b0, 32'h0},
      '{32'h003, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 32'h0},
      '{32'h011, 1'b0, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0},
      '{32'h013, 1'b1, 3'd0, 32'h77000000, 1'b0, 1'b0, 32'h0},
      '{32'h010, 1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'h77ADBEEF}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("rst hready0", rdy0, 1); chk("rst hresp0", rsp0, 0); chk("rst hrdata0", rd0, 0);
    chk("rst hready2", rdy2, 1); chk("rst hresp2", rsp2, 0); chk("rst hrdata2", rd2, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    sel = 0;
    for (int k = 0; k < 23; k++) begin
      x.addr = tbl[k].addr; x.wr = tbl[k].wr; x.size = tbl[k].size; x.wdata = tbl[k].wdata;
      x = model(x);
      x.e_err = tbl[k].err;
      x.e_mask = tbl[k].chk ? 32'hFFFFFFFF : 32'h0;
      x.e_rdata = tbl[k].rdata;
      q.push_back(x);
    end
    run_seq("table");
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int k = 0; k < 4; k++) add(32'h100 + 32'(4 * k), 1'b1, 3'd2, 32'($urandom));
      for (int k = 0; k < 4; k++) add(32'h100 + 32'(4 * k), 1'b0, 3'd2, 32'h0);
      run_seq(s != 0 ? "incr4_ws2" : "incr4_ws0");
      gen_rand(80);
      run_seq(s != 0 ? "rand_ws2" : "rand_ws0");
    end
    sel = 1;
    add(32'h200, 1'b1, 3'd2, 32'hCAFEF00D);
    run_seq("pre_reset_write");
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h200; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'd0; hwdata = 32'h0BADF00D;
    chk("wait before reset hready", rdy2, 0);
    #2 rst = 1'b1;
    #1;
    chk("async rst hready", rdy2, 1); chk("async rst hresp", rsp2, 0); chk("async rst hrdata", rd2, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    add(32'h200, 1'b0, 3'd2, 32'h0);
    run_seq("post_reset_read");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
